// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag register layout and lane geometry for the
// pipelined ALU.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int LANE_W = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_PT0    = 4'hC,
        OP_PT1    = 4'hD,
        OP_PT2    = 4'hE,
        OP_PT3    = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } alu_flags_t;

    function automatic logic writes_nzv(alu_op_e op);
        return op inside {OP_ADD, OP_SUB};
    endfunction

    function automatic logic writes_z_only(alu_op_e op);
        return op inside {OP_XOR, OP_SLL, OP_SRA, OP_ROR};
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between decode, the ALU and writeback.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_sat, flag_n, flag_z, flag_v
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_sat, flag_n, flag_z, flag_v
    );
endinterface

// File: rtl/sat_addsub.sv
// Signed W-bit add/subtract that clamps to the representable range and
// reports whether clamping happened.
module sat_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         sat
);
    logic [W:0] ext;

    always_comb begin
        ext = sub ? ({a[W-1], a} - {b[W-1], b})
                  : ({a[W-1], a} + {b[W-1], b});
        // The extra sign bit disagrees with the result MSB exactly on overflow.
        sat = ext[W] ^ ext[W-1];
        if (!sat)
            sum = ext[W-1:0];
        else if (ext[W])
            sum = {1'b1, {(W-1){1'b0}}};
        else
            sum = {1'b0, {(W-1){1'b1}}};
    end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 captures operands, S2 holds the computed result
// and the N/Z/V flag register; valid/ready on both sides lets the core stall it.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam int NLANES = WIDTH / LANE_W;
    localparam int NBYTES = WIDTH / BYTE_W;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic             s2_sat;
    alu_flags_t       flags_q;
    alu_flags_t       flags_next;

    logic             s2_load;
    logic             s1_adv;
    logic             accept;

    logic [WIDTH-1:0] res;
    logic             res_sat;

    assign s2_load      = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_load;
    assign bus.in_ready = !s1_valid || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------- stage 1: operand capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is always written with <= so every register samples pre-edge values.
        if (rst)
            s1_valid <= 1'b0;
        else if (bus.in_ready)
            s1_valid <= bus.in_valid;
    end

    // NOTE: operand registers carry no reset; s1_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a  <= bus.in_a;
            s1_b  <= bus.in_b;
            s1_op <= alu_op_e'(bus.in_op);
        end
    end

    // ---------------- execute ----------------
    logic [WIDTH-1:0] as_sum;
    logic             as_sat;

    sat_addsub #(.W(WIDTH)) u_addsub (
        .a   (s1_a),
        .b   (s1_b),
        .sub (s1_op == OP_SUB),
        .sum (as_sum),
        .sat (as_sat)
    );

    logic [WIDTH-1:0]  pb_sum;
    logic [NLANES-1:0] pb_sat;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        sat_addsub #(.W(LANE_W)) u_lane (
            .a   (s1_a[g*LANE_W +: LANE_W]),
            .b   (s1_b[g*LANE_W +: LANE_W]),
            .sub (1'b0),
            .sum (pb_sum[g*LANE_W +: LANE_W]),
            .sat (pb_sat[g])
        );
    end

    logic [SHW-1:0]   sh;
    logic [SHW:0]     rsh;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH-1:0] addr_res;

    assign sh       = s1_b[SHW-1:0];
    assign rsh      = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign sll_res  = s1_a << sh;
    assign sra_res  = $signed(s1_a) >>> sh;
    // A left shift by the full width yields zero, so sh=0 rotates to a itself.
    assign ror_res  = (s1_a >> sh) | (s1_a << rsh);
    assign addr_res = {s1_a[WIDTH-1:1], 1'b0} + s1_b;

    logic [WIDTH-1:0] red_sum;

    always_comb begin
        // NOTE: combinational accumulators use blocking = and start from a default, so no latch forms.
        red_sum = '0;
        for (int i = 0; i < NBYTES; i++) begin
            red_sum = red_sum
                    + {{(WIDTH-BYTE_W){s1_a[i*BYTE_W+BYTE_W-1]}}, s1_a[i*BYTE_W +: BYTE_W]}
                    + {{(WIDTH-BYTE_W){s1_b[i*BYTE_W+BYTE_W-1]}}, s1_b[i*BYTE_W +: BYTE_W]};
        end
    end

    always_comb begin
        res     = s1_a;
        res_sat = 1'b0;
        case (s1_op)
            OP_ADD, OP_SUB: begin
                res     = as_sum;
                res_sat = as_sat;
            end
            OP_XOR:       res = s1_a ^ s1_b;
            OP_RED:       res = red_sum;
            OP_SLL:       res = sll_res;
            OP_SRA:       res = sra_res;
            OP_ROR:       res = ror_res;
            OP_PADDSB: begin
                res     = pb_sum;
                res_sat = |pb_sat;
            end
            OP_LW, OP_SW: res = addr_res;
            OP_LLB:       res = {s1_a[WIDTH-1:BYTE_W], s1_b[BYTE_W-1:0]};
            OP_LHB:       res = {s1_b[BYTE_W-1:0], s1_a[WIDTH-BYTE_W-1:0]};
            default:      res = s1_a;
        endcase
    end

    always_comb begin
        flags_next = flags_q;
        if (writes_nzv(s1_op)) begin
            flags_next.n = res[WIDTH-1];
            flags_next.z = (res == '0);
            flags_next.v = res_sat;
        end else if (writes_z_only(s1_op)) begin
            flags_next.z = (res == '0);
        end
    end

    // ---------------- stage 2: result and flag register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
            flags_q  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= res;
                s2_sat  <= res_sat;
                flags_q <= flags_next;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_sat   = s2_sat;
    assign bus.flag_n    = flags_q.n;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against an arithmetic reference
// model with an in-order scoreboard; a 32-bit instance covers wide saturation.
module tb_alu_pipe;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        logic [2:0]  nzv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(16)) bus ();
    alu_pipe_if #(.WIDTH(32)) bus32 ();

    alu_pipe #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    int n_cmp = 0;
    int n_err = 0;

    exp_t       sb_q[$];
    logic [2:0] mdl_nzv = 3'b000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp(input int v, input int lo, input int hi, inout logic sat);
        if (v > hi) begin sat = 1'b1; return hi; end
        if (v < lo) begin sat = 1'b1; return lo; end
        return v;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [2:0] nzv_in);
        exp_t        e;
        int          sa, sb, s, sh, la, lb;
        longint      p;
        byte         x;
        logic [15:0] r;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        sh    = int'(b[3:0]);
        e.sat = 1'b0;
        e.nzv = nzv_in;
        case (op)
            4'h0: begin s = clamp(sa + sb, -32768, 32767, e.sat); e.data = s[15:0]; end
            4'h1: begin s = clamp(sa - sb, -32768, 32767, e.sat); e.data = s[15:0]; end
            4'h2: e.data = a ^ b;
            4'h3: begin
                s = 0;
                for (int i = 0; i < 2; i++) begin
                    x = a[8*i +: 8]; s += x;
                    x = b[8*i +: 8]; s += x;
                end
                e.data = s[15:0];
            end
            4'h4: begin p = longint'(a) * (longint'(1) << sh); e.data = p[15:0]; end
            4'h5: begin
                s = sa;
                for (int k = 0; k < sh; k++) s = (s - (s & 1)) / 2;
                e.data = s[15:0];
            end
            4'h6: begin
                r = a;
                for (int k = 0; k < sh; k++) r = {r[0], r[15:1]};
                e.data = r;
            end
            4'h7: begin
                for (int i = 0; i < 4; i++) begin
                    la = int'(a[4*i +: 4]); if (la > 7) la -= 16;
                    lb = int'(b[4*i +: 4]); if (lb > 7) lb -= 16;
                    s  = clamp(la + lb, -8, 7, e.sat);
                    r[4*i +: 4] = s[3:0];
                end
                e.data = r;
            end
            4'h8, 4'h9: e.data = (a & 16'hFFFE) + b;
            4'hA: e.data = {a[15:8], b[7:0]};
            4'hB: e.data = {b[7:0], a[7:0]};
            default: e.data = a;
        endcase
        if (op <= 4'h1)
            e.nzv = {e.data[15], e.data == 16'h0, e.sat};
        else if (op inside {4'h2, 4'h4, 4'h5, 4'h6})
            e.nzv[1] = (e.data == 16'h0);
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data",  bus.out_data, e.data);
                    check("sb_sat",   bus.out_sat,  e.sat);
                    check("sb_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, e.nzv);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e       = model(bus.in_op, bus.in_a, bus.in_b, mdl_nzv);
                mdl_nzv = e.nzv;
                sb_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic got;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        got          = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = bus.in_ready;
        end
        check("send_accept", got, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp_d,
                            input logic exp_s, input logic [2:0] exp_f);
        send(op, a, b);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_data"},  bus.out_data,  exp_d);
        check({tag, "_sat"},   bus.out_sat,   exp_s);
        check({tag, "_flags"}, {bus.flag_n, bus.flag_z, bus.flag_v}, exp_f);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    logic [3:0]  bp_op [3] = '{4'h0, 4'h1, 4'h0};
    logic [15:0] bp_a  [3] = '{16'h0001, 16'h0005, 16'h8000};
    logic [15:0] bp_b  [3] = '{16'h0002, 16'h0005, 16'hFFFF};
    logic [15:0] bp_d  [3] = '{16'h0003, 16'h0000, 16'h8000};
    logic [2:0]  bp_f  [3] = '{3'b000, 3'b010, 3'b101};

    initial begin : main
        int          idx;
        int          got;
        logic        acc;
        logic [15:0] got_d [3];
        logic [2:0]  got_f [3];

        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_op      = '0;
        bus.out_ready  = 1'b1;
        bus32.in_valid = 1'b0;
        bus32.in_a     = '0;
        bus32.in_b     = '0;
        bus32.in_op    = '0;
        bus32.out_ready = 1'b1;

        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  16'h0);
        check("rst_out_sat",   bus.out_sat,   1'b0);
        check("rst_flags",     {bus.flag_n, bus.flag_z, bus.flag_v}, 3'b000);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        op_check("add_sat",    4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 3'b001);
        op_check("sub_zero",   4'h1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b010);
        op_check("xor_keepnv", 4'h2, 16'h00FF, 16'h0F00, 16'h0FFF, 1'b0, 3'b000);
        op_check("add_negsat", 4'h0, 16'h8000, 16'h8000, 16'h8000, 1'b1, 3'b101);
        op_check("xor_zero",   4'h2, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b111);
        op_check("paddsb",     4'h7, 16'h7878, 16'h1919, 16'h7878, 1'b1, 3'b111);
        op_check("red",        4'h3, 16'h0102, 16'h0304, 16'h000A, 1'b0, 3'b111);
        op_check("ror",        4'h6, 16'h8001, 16'h0001, 16'hC000, 1'b0, 3'b101);
        op_check("sra",        4'h5, 16'h8000, 16'h0004, 16'hF800, 1'b0, 3'b101);
        op_check("sll",        4'h4, 16'h0001, 16'h000F, 16'h8000, 1'b0, 3'b101);
        op_check("lw_addr",    4'h8, 16'h1235, 16'h0010, 16'h1244, 1'b0, 3'b101);
        op_check("llb",        4'hA, 16'hABCD, 16'h0012, 16'hAB12, 1'b0, 3'b101);
        op_check("lhb",        4'hB, 16'hABCD, 16'h0034, 16'h34CD, 1'b0, 3'b101);
        op_check("passthru",   4'hE, 16'h5A5A, 16'hFFFF, 16'h5A5A, 1'b0, 3'b101);
        op_check("xor_zero2",  4'h2, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b111);

        // Backpressure: three ops offered while the consumer is stalled.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.in_valid = (idx < 3);
            if (idx < 3) begin
                bus.in_op = bp_op[idx];
                bus.in_a  = bp_a[idx];
                bus.in_b  = bp_b[idx];
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_accepted",  idx, 2);
        check("bp_in_ready",  bus.in_ready,  1'b0);
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_held_data", bus.out_data,  16'h0003);
        check("bp_held_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, 3'b000);

        bus.out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 12 && got < 3; t++) begin
            bus.in_valid = (idx < 3);
            if (idx < 3) begin
                bus.in_op = bp_op[idx];
                bus.in_a  = bp_a[idx];
                bus.in_b  = bp_b[idx];
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                got_d[got] = bus.out_data;
                got_f[got] = {bus.flag_n, bus.flag_z, bus.flag_v};
                got++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        check("bp_result_count", got, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got) begin
                check("bp_order_data",  got_d[i], bp_d[i]);
                check("bp_order_flags", got_f[i], bp_f[i]);
            end
        end

        // Wide instance: same saturation corner at 32 bits.
        bus32.in_op    = 4'h0;
        bus32.in_a     = 32'h7FFF_FFFF;
        bus32.in_b     = 32'h0000_0001;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        check("w32_in_ready", bus32.in_ready, 1'b1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w32_valid", bus32.out_valid, 1'b1);
        check("w32_data",  bus32.out_data,  32'h7FFF_FFFF);
        check("w32_sat",   bus32.out_sat,   1'b1);
        check("w32_flags", {bus32.flag_n, bus32.flag_z, bus32.flag_v}, 3'b001);
        @(posedge clk); #1;

        // Reset with both stages occupied.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6 && idx < 2; cyc++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = (idx == 0) ? 4'h0 : 4'h2;
            bus.in_a     = 16'h7FFF;
            bus.in_b     = 16'h0001;
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        check("rf_filled",    idx, 2);
        check("rf_pre_valid", bus.out_valid, 1'b1);
        check("rf_pre_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        check("rf_out_valid", bus.out_valid, 1'b0);
        check("rf_flags",     {bus.flag_n, bus.flag_z, bus.flag_v}, 3'b000);
        check("rf_out_data",  bus.out_data,  16'h0);
        check("rf_in_ready",  bus.in_ready,  1'b1);
        sb_q.delete();
        mdl_nzv = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("rf_no_emit", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Random traffic against the scoreboard.
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_op     = 4'($urandom_range(0, 15));
            bus.in_a      = pick();
            bus.in_b      = pick();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", sb_q.size(), 0);
        check("drain_valid", bus.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
